// File: rtl/mprj_io_serial_pkg.sv
// Shared types and constants for the serial IO-configuration loader.
package mprj_io_serial_pkg;

  localparam int MPRJ_N_IO  = 38;
  localparam int MPRJ_CFG_W = 13;

  typedef enum logic [2:0] {
    IDLE,
    SHIFT_LO,
    SHIFT_HI,
    LOAD,
    DONE
  } xfer_state_t;

  // Cycles from the start-sampling edge to the cycle in which done is high.
  function automatic int xfer_latency(input int div, input int n_io, input int cfg_w);
    return 1 + 2 * div * n_io * cfg_w + div;
  endfunction

endpackage

// File: rtl/mprj_io_serial_tick.sv
// Phase-tick generator: counts 0..DIV-1, tick is high on the last cycle of each phase.
// restart holds the count at zero so the first phase after it is a full DIV cycles.
module mprj_io_serial_tick #(
  parameter int unsigned DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic tick
);

  localparam logic [7:0] LAST = 8'(DIV - 1);

  logic [7:0] cnt;

  assign tick = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (rst || restart || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 8'd1;
    end
  end

endmodule

// File: rtl/mprj_io_serial_loader.sv
// Shifts the per-pad IO config words into the GPIO control chain, then pulses load.
// Latency 1 + 2*DIV*N_IO*CFG_W + DIV cycles; starts while busy are dropped, never queued.
module mprj_io_serial_loader
  import mprj_io_serial_pkg::*;
#(
  parameter int unsigned N_IO  = MPRJ_N_IO,
  parameter int unsigned CFG_W = MPRJ_CFG_W,
  parameter int unsigned DIV   = 2
) (
  input  logic                  wb_clk_i,
  input  logic                  wb_rst_i,
  input  logic [N_IO*CFG_W-1:0] io_cfg_i,
  input  logic                  xfer_start_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  serial_clock_o,
  output logic                  serial_data_o,
  output logic                  serial_load_o,
  output logic                  serial_resetn_o
);

  localparam int unsigned TOTAL = N_IO * CFG_W;
  localparam int unsigned CNT_W = $clog2(TOTAL + 1);
  localparam logic [31:0] LAT   = 32'(xfer_latency(int'(DIV), int'(N_IO), int'(CFG_W)));

  xfer_state_t      state;
  logic [TOTAL-1:0] shreg;
  logic [CNT_W-1:0] bit_cnt;
  logic             tick;
  logic             restart;
  logic [31:0]      lat_cnt;

  // Phases only run inside SHIFT_LO/SHIFT_HI/LOAD; elsewhere the counter is parked at zero.
  assign restart = (state == IDLE) || (state == DONE);

  mprj_io_serial_tick #(
    .DIV(DIV)
  ) u_tick (
    .clk    (wb_clk_i),
    .rst    (wb_rst_i),
    .restart(restart),
    .tick   (tick)
  );

  always_ff @(posedge wb_clk_i) begin
    serial_resetn_o <= ~wb_rst_i;
    if (wb_rst_i) begin
      state          <= IDLE;
      shreg          <= '0;
      bit_cnt        <= '0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      serial_clock_o <= 1'b0;
      serial_data_o  <= 1'b0;
      serial_load_o  <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (xfer_start_i) begin
            shreg         <= io_cfg_i;
            bit_cnt       <= CNT_W'(TOTAL);
            busy_o        <= 1'b1;
            serial_data_o <= io_cfg_i[TOTAL-1];
            state         <= SHIFT_LO;
          end
        end
        SHIFT_LO: begin
          if (tick) begin
            serial_clock_o <= 1'b1;
            state          <= SHIFT_HI;
          end
        end
        SHIFT_HI: begin
          if (tick) begin
            serial_clock_o <= 1'b0;
            shreg          <= {shreg[TOTAL-2:0], 1'b0};
            if (bit_cnt != '0) begin
              bit_cnt <= bit_cnt - CNT_W'(1);
            end
            // bit_cnt still holds the pre-decrement value: 1 means the last bit just went out.
            if (bit_cnt <= CNT_W'(1)) begin
              serial_load_o <= 1'b1;
              serial_data_o <= 1'b0;
              state         <= LOAD;
            end else begin
              serial_data_o <= shreg[TOTAL-2];
              state         <= SHIFT_LO;
            end
          end
        end
        LOAD: begin
          if (tick) begin
            serial_load_o <= 1'b0;
            done_o        <= 1'b1;
            busy_o        <= 1'b0;
            state         <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || state == IDLE) begin
      lat_cnt <= '0;
    end else begin
      lat_cnt <= lat_cnt + 32'd1;
    end
  end

  a_latency: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    (state == DONE) |-> (lat_cnt + 32'd1 == LAT));

  a_data_tracks_msb: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    (state == SHIFT_LO) |-> (serial_data_o == shreg[TOTAL-1]));

  a_done_not_busy: assert property (@(posedge wb_clk_i) disable iff (wb_rst_i)
    done_o |-> !busy_o);

endmodule
